// File: rtl/gin_mcast_buffered.sv
`default_nettype none
// ============================================================================
// Module   : gin_mcast_buffered
// Purpose  : Buffered multicast input network; FIFO-fed tagged packets are
//            delivered to every PE whose scanned row/col ID matches (all-ones
//            ID = wildcard). A packet retires once every target has taken it.
// Revision : 1.0 - initial release
// ============================================================================
module gin_mcast_buffered #(
  parameter int XBUS_NUMS  = 12,
  parameter int PE_NUMS    = 14,
  parameter int ID_LEN     = 5,
  parameter int ROW_LEN    = 4,
  parameter int VALUE_LEN  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MISS_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROW_LEN-1:0]                        row_tag,
  input  logic [ID_LEN-1:0]                         col_tag,
  input  logic [VALUE_LEN-1:0]                      value,
  input  logic                                      set_row,
  input  logic [ROW_LEN-1:0]                        row_scan_in,
  output logic [ROW_LEN-1:0]                        row_scan_out,
  input  logic                                      set_id,
  input  logic [ID_LEN-1:0]                         id_scan_in,
  output logic [ID_LEN-1:0]                         id_scan_out,
  input  logic [XBUS_NUMS*PE_NUMS-1:0]              pe_ready,
  output logic [XBUS_NUMS*PE_NUMS*(VALUE_LEN+1)-1:0] pe_enable_data,
  output logic                                      busy,
  output logic [MISS_W-1:0]                         miss_cnt
);

  localparam int NPE = XBUS_NUMS * PE_NUMS;
  localparam int SLW = VALUE_LEN + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  logic [XBUS_NUMS-1:0][ROW_LEN-1:0] r_row_id;
  logic [NPE-1:0][ID_LEN-1:0]        r_col_id;
  logic [ROW_LEN-1:0]                r_fifo_row [FIFO_DEPTH];
  logic [ID_LEN-1:0]                 r_fifo_col [FIFO_DEPTH];
  logic [VALUE_LEN-1:0]              r_fifo_val [FIFO_DEPTH];
  logic [AW:0]                       r_wptr;
  logic [AW:0]                       r_rptr;
  state_t                            r_state;
  logic [NPE-1:0]                    r_pending;
  logic [VALUE_LEN-1:0]              r_value;
  logic [MISS_W-1:0]                 r_miss;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_busy;
  logic                 w_push;
  logic                 w_slot_free;
  logic [NPE-1:0]       w_pend_left;
  logic [ROW_LEN-1:0]   w_head_row;
  logic [ID_LEN-1:0]    w_head_col;
  logic [VALUE_LEN-1:0] w_head_val;
  logic [XBUS_NUMS-1:0] w_bus_hit;
  logic [NPE-1:0]       w_mask;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_busy      = !w_empty || (r_state == S_SEND);
  assign w_push      = in_valid && !w_full;
  assign w_pend_left = r_pending & ~pe_ready;
  assign w_slot_free = (r_state == S_IDLE) || (w_pend_left == '0);
  assign w_head_row  = r_fifo_row[r_rptr[AW-1:0]];
  assign w_head_col  = r_fifo_col[r_rptr[AW-1:0]];
  assign w_head_val  = r_fifo_val[r_rptr[AW-1:0]];

  assign in_ready     = !w_full;
  assign busy         = w_busy;
  assign miss_cnt     = r_miss;
  assign row_scan_out = r_row_id[XBUS_NUMS-1];
  assign id_scan_out  = r_col_id[NPE-1];

  generate
    for (genvar b = 0; b < XBUS_NUMS; b++) begin : g_bus
      assign w_bus_hit[b] = (r_row_id[b] == w_head_row) || (&r_row_id[b]);
    end
    for (genvar k = 0; k < NPE; k++) begin : g_pe
      assign w_mask[k] = w_bus_hit[k / PE_NUMS] &&
                         ((r_col_id[k] == w_head_col) || (&r_col_id[k]));
      assign pe_enable_data[k*SLW +: SLW] = {r_pending[k], r_value};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_row[r_wptr[AW-1:0]] <= row_tag;
      r_fifo_col[r_wptr[AW-1:0]] <= col_tag;
      r_fifo_val[r_wptr[AW-1:0]] <= value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_slot_free && !w_empty)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  // IDs must not move under a packet that is being matched or delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_id <= '0;
      r_col_id <= '0;
    end else begin
      if (set_row && !w_busy)
        r_row_id <= {r_row_id[XBUS_NUMS-2:0], row_scan_in};
      if (set_id && !w_busy)
        r_col_id <= {r_col_id[NPE-2:0], id_scan_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_value   <= '0;
      r_miss    <= '0;
    end else if (w_slot_free) begin
      if (w_empty) begin
        r_state   <= S_IDLE;
        r_pending <= '0;
      end else begin
        r_value   <= w_head_val;
        r_pending <= w_mask;
        if (w_mask == '0) begin
          r_state <= S_IDLE;
          if (r_miss != '1)
            r_miss <= r_miss + 1'b1;
        end else begin
          r_state <= S_SEND;
        end
      end
    end else begin
      r_pending <= w_pend_left;
    end
  end

endmodule
`default_nettype wire
